// File: rtl/sha256_seq.sv
// ============================================================================
//  Module      : sha256_seq
//  Description : Iterative SHA-256 compression, one round per clock, rolling
//                16-word schedule, chaining state held across blocks.
//                Optional abort port enabled by SHA256_SEQ_ABORT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_seq (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         first,
    input  logic [0:511] block,
`ifdef SHA256_SEQ_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic [0:255] digest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2
    } state_t;

    localparam logic [31:0] C_IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] C_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t       state_q, state_d;
    logic [5:0]   t_q, t_d;
    logic         done_q, done_d;
    logic [31:0]  h_q [8];
    logic [31:0]  h_d [8];
    logic [31:0]  v_q [8];   // working variables a..h at indices 0..7
    logic [31:0]  v_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [0:255] dig_q, dig_d;
    logic         abort_req;
    logic [31:0]  t1, t2, w_new;

`ifdef SHA256_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        t1 = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]))
           + C_K[t_q] + w_q[0];
        t2 = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
        w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        done_d  = 1'b0;
        h_d     = h_q;
        v_d     = v_q;
        w_d     = w_q;
        dig_d   = dig_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int j = 0; j < 16; j++) begin
                        w_d[j] = block[j*32 +: 32];
                    end
                    for (int i = 0; i < 8; i++) begin
                        v_d[i] = first ? C_IV[i] : h_q[i];
                        if (first) begin
                            h_d[i] = C_IV[i];
                        end
                    end
                    t_d     = 6'd0;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                if (abort_req) begin
                    state_d = IDLE;
                end else begin
                    v_d[7] = v_q[6];
                    v_d[6] = v_q[5];
                    v_d[5] = v_q[4];
                    v_d[4] = v_q[3] + t1;
                    v_d[3] = v_q[2];
                    v_d[2] = v_q[1];
                    v_d[1] = v_q[0];
                    v_d[0] = t1 + t2;
                    for (int i = 0; i < 15; i++) begin
                        w_d[i] = w_q[i+1];
                    end
                    w_d[15] = w_new;
                    t_d     = t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                state_d = IDLE;
                // Abort wins here too, so H and the digest keep their old values
                if (!abort_req) begin
                    for (int i = 0; i < 8; i++) begin
                        h_d[i]             = h_q[i] + v_q[i];
                        dig_d[i*32 +: 32]  = h_q[i] + v_q[i];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                h_q[i]            <= C_IV[i];
                v_q[i]            <= 32'd0;
                dig_q[i*32 +: 32] <= C_IV[i];
            end
            for (int j = 0; j < 16; j++) begin
                w_q[j] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            done_q  <= done_d;
            h_q     <= h_d;
            v_q     <= v_d;
            w_q     <= w_d;
            dig_q   <= dig_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign digest = dig_q;

endmodule

`default_nettype wire
